// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM state encodings and
// the counter-width helper used to size the chunk counter.
package multicycle_adder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicycle_adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells; the
// chunk-serial top feeds it one slice of the operands per clock.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out
);

  logic [CHUNK:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .s     (sum[i]),
      .c_out (carry[i+1])
    );
  end

  assign c_out = carry[CHUNK];

endmodule

// File: rtl/multicycle_adder.sv
// Chunk-serial adder/subtractor: operands captured on start, CHUNK bits are
// added per clock LSB first, flags and a one-cycle done pulse after NCHUNK edges.
//
// Handshake: start is sampled only at an edge where busy=0; that edge captures
// a, b, sub and carry_in. done is a one-cycle pulse NCHUNK edges later, during
// which busy=0, so a start in the done cycle is accepted back-to-back.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic [WIDTH-1:0] sum_shift;
  logic             last_chunk;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .c_in  (carry_q),
    .sum   (chunk_sum),
    .c_out (chunk_cout)
  );

  // New chunk enters from the top so chunk k lands at [k*CHUNK +: CHUNK].
  if (NCHUNK == 1) begin : g_single
    assign sum_shift = chunk_sum;
  end else begin : g_multi
    assign sum_shift = {chunk_sum, sum_q[WIDTH-1:CHUNK]};
  end

  assign last_chunk = (cnt_q == CNT_LAST);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)      state_d = ST_RUN;
      ST_RUN:  if (last_chunk) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q == ST_RUN);
    dbg_state = state_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : carry_in;
          a_msb_d = a[WIDTH-1];
          b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = sum_shift;
        carry_d = chunk_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          cnt_d       = '0;
          carry_out_d = chunk_cout;
          // Same-sign operands producing a result of the other sign.
          overflow_d  = (a_msb_q == b_msb_q) && (sum_shift[WIDTH-1] != a_msb_q);
          zero_d      = (sum_shift == '0);
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      done_q      <= done_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign done      = done_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder: directed cases, handshake stress,
// async reset mid-operation and random sweeps over four WIDTH/CHUNK configs.
module tb_multicycle_adder;
  import multicycle_adder_pkg::*;

  logic clk;
  logic rst;
  int   cyc;

  // Instance 0: 32/8, 1: 32/32, 2: 32/1, 3: 16/8
  logic        start_v [4];
  logic        sub_v   [4];
  logic        cin_v   [4];
  logic [31:0] a_v     [4];
  logic [31:0] b_v     [4];
  logic [31:0] sum_w   [4];
  logic        cout_w  [4];
  logic        ovf_w   [4];
  logic        zero_w  [4];
  logic        busy_w  [4];
  logic        done_w  [4];
  state_t      st_w    [4];
  logic [15:0] sum16;

  logic [34:0] exp_q[$];
  int          lat_q[$];

  int n_checks;
  int n_fail;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a(a_v[0]), .b(b_v[0]),
    .carry_in(cin_v[0]), .sum(sum_w[0]), .carry_out(cout_w[0]), .overflow(ovf_w[0]),
    .zero(zero_w[0]), .busy(busy_w[0]), .done(done_w[0]), .dbg_state(st_w[0])
  );

  multicycle_adder #(.WIDTH(32), .CHUNK(32)) dut_c32 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a(a_v[1]), .b(b_v[1]),
    .carry_in(cin_v[1]), .sum(sum_w[1]), .carry_out(cout_w[1]), .overflow(ovf_w[1]),
    .zero(zero_w[1]), .busy(busy_w[1]), .done(done_w[1]), .dbg_state(st_w[1])
  );

  multicycle_adder #(.WIDTH(32), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]), .a(a_v[2]), .b(b_v[2]),
    .carry_in(cin_v[2]), .sum(sum_w[2]), .carry_out(cout_w[2]), .overflow(ovf_w[2]),
    .zero(zero_w[2]), .busy(busy_w[2]), .done(done_w[2]), .dbg_state(st_w[2])
  );

  multicycle_adder #(.WIDTH(16), .CHUNK(8)) dut_w16 (
    .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub_v[3]), .a(a_v[3][15:0]),
    .b(b_v[3][15:0]), .carry_in(cin_v[3]), .sum(sum16), .carry_out(cout_w[3]),
    .overflow(ovf_w[3]), .zero(zero_w[3]), .busy(busy_w[3]), .done(done_w[3]),
    .dbg_state(st_w[3])
  );

  assign sum_w[3] = {16'h0000, sum16};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int width_of(input int idx);
    return (idx == 3) ? 16 : 32;
  endfunction

  function automatic int nchunk_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 1;
      2:       return 32;
      default: return 2;
    endcase
  endfunction

  function automatic logic [34:0] pack(input logic [31:0] s, input logic c, input logic o,
                                       input logic z);
    return {s, c, o, z};
  endfunction

  // Behavioural reference: plain wide addition, then mask to the instance width.
  function automatic logic [34:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic sv, input logic cv);
    logic [63:0] m, aa, bb, r;
    logic [31:0] s;
    logic        co, ov;
    m  = (64'd1 << w) - 64'd1;
    aa = {32'h0, av} & m;
    bb = (sv ? ~{32'h0, bv} : {32'h0, bv}) & m;
    r  = aa + bb + 64'(sv ? 1'b1 : cv);
    s  = r[31:0] & m[31:0];
    co = r[w];
    ov = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {s, co, ov, (s == 32'h0)};
  endfunction

  // scoreboard: pop and compare on every done pulse
  logic [34:0] mon_e;
  int          mon_l;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_w[i]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("spurious_done%0d", i), 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          check($sformatf("latency%0d", i), 64'(cyc), 64'(mon_l));
          check($sformatf("sum%0d", i), 64'(sum_w[i]), 64'(mon_e[34:3]));
          check($sformatf("carry_out%0d", i), 64'(cout_w[i]), 64'(mon_e[2]));
          check($sformatf("overflow%0d", i), 64'(ovf_w[i]), 64'(mon_e[1]));
          check($sformatf("zero%0d", i), 64'(zero_w[i]), 64'(mon_e[0]));
          check($sformatf("busy_in_done%0d", i), 64'(busy_w[i]), 64'd0);
        end
      end
    end
  end

  // driver: called at a negedge, returns at the negedge after the accepting edge
  task automatic issue(input int idx, input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, input logic cv, input logic [34:0] exp);
    int g;
    g = 0;
    while (busy_w[idx] && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy_w[idx]) check("busy_wait_timeout", 64'(busy_w[idx]), 64'd0);
    a_v[idx]     = av;
    b_v[idx]     = bv;
    sub_v[idx]   = sv;
    cin_v[idx]   = cv;
    start_v[idx] = 1'b1;
    exp_q.push_back(exp);
    lat_q.push_back(cyc + 1 + nchunk_of(idx));
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // start held every cycle with fresh operands; only busy=0 cycles are accepts
  task automatic stream(input int idx, input int n);
    logic [31:0] av, bv;
    logic        sv, cv;
    for (int k = 0; k < n; k++) begin
      av = $urandom();
      bv = $urandom();
      sv = 1'($urandom_range(0, 1));
      cv = 1'($urandom_range(0, 1));
      a_v[idx]     = av;
      b_v[idx]     = bv;
      sub_v[idx]   = sv;
      cin_v[idx]   = cv;
      start_v[idx] = 1'b1;
      if (!busy_w[idx]) begin
        exp_q.push_back(model(width_of(idx), av, bv, sv, cv));
        lat_q.push_back(cyc + 1 + nchunk_of(idx));
      end
      @(negedge clk);
    end
    start_v[idx] = 1'b0;
  endtask

  task automatic run_random(input int idx, input int n);
    logic [31:0] av, bv;
    logic        sv, cv;
    for (int k = 0; k < n; k++) begin
      av = $urandom();
      bv = $urandom();
      sv = 1'($urandom_range(0, 1));
      cv = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       av = 32'hFFFF_FFFF;
        1:       bv = av;
        2:       av = 32'h7FFF_FFFF;
        default: ;
      endcase
      issue(idx, av, bv, sv, cv, model(width_of(idx), av, bv, sv, cv));
    end
    wait_drain();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      sub_v[i]   = 1'b0;
      cin_v[i]   = 1'b0;
      a_v[i]     = 32'h0;
      b_v[i]     = 32'h0;
    end
    repeat (3) @(negedge clk);
    check("rst_sum", 64'(sum_w[0]), 64'd0);
    check("rst_carry_out", 64'(cout_w[0]), 64'd0);
    check("rst_overflow", 64'(ovf_w[0]), 64'd0);
    check("rst_zero", 64'(zero_w[0]), 64'd0);
    check("rst_busy", 64'(busy_w[0]), 64'd0);
    check("rst_done", 64'(done_w[0]), 64'd0);
    check("rst_state", 64'(st_w[0]), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // basic add, then result held in IDLE
    issue(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, pack(32'h0000_0008, 1'b0, 1'b0, 1'b0));
    wait_drain();
    repeat (3) @(negedge clk);
    check("sum_hold", 64'(sum_w[0]), 64'h8);
    check("done_low_idle", 64'(done_w[0]), 64'd0);

    // carry through every chunk boundary, signed overflow, subtract with borrow
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, pack(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, pack(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    issue(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, pack(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    issue(0, 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, pack(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    issue(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, pack(32'h0000_0001, 1'b1, 1'b0, 1'b0));
    wait_drain();

    stream(0, 40);
    wait_drain();

    // async reset in the second RUN cycle abandons the operation
    issue(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, pack(32'h2345_6789, 1'b0, 1'b0, 1'b0));
    check("busy_run", 64'(busy_w[0]), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_sum", 64'(sum_w[0]), 64'd0);
    check("arst_carry_out", 64'(cout_w[0]), 64'd0);
    check("arst_zero", 64'(zero_w[0]), 64'd0);
    check("arst_busy", 64'(busy_w[0]), 64'd0);
    check("arst_done", 64'(done_w[0]), 64'd0);
    check("arst_state", 64'(st_w[0]), 64'(ST_IDLE));
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, pack(32'h0000_0008, 1'b0, 1'b0, 1'b0));
    wait_drain();

    // configuration sweep against the behavioural reference
    run_random(0, 1000);
    run_random(1, 1000);
    run_random(2, 300);
    run_random(3, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
